// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep controller and its signature register.
package sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StOut,
    StDone
  } sweep_state_e;

  localparam logic [3:0]  IDX_LAST = 4'd15;
  localparam logic [15:0] SIG_INIT = 16'hFFFF;
  localparam logic [15:0] SIG_POLY = 16'h1021;

  // One MISR step: shift with feedback from bit 15 (Galois form), then fold in the row data.
  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [9:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? SIG_POLY : 16'h0000) ^ {6'b0, d};
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// 16-bit multiple-input signature register over captured row data.
module sweep_misr
  import sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [9:0]  din,
  output logic [15:0] sig
);

  logic [15:0] sig_q, sig_d;

  // Load takes priority so a fresh sweep always starts from the seed.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SIG_INIT;
    end else if (en) begin
      sig_d = misr_next(sig_q, din);
    end
  end

  // Signature register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 16'h0000;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/sweep_ctrl.sv
// Sweeps a 4-input combinational block through all 16 input combinations, waits a
// configurable settle time per row and hands each captured result to a consumer.
// Optional row signature enabled by defining SWEEP_SIG_EN; otherwise sig reads zero.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1  // legal 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  wxyz,
  input  logic [9:0]  f_in,
  output logic        row_valid,
  input  logic        row_ready,
  output logic [3:0]  row_idx,
  output logic [9:0]  row_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] sig
);

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  sweep_state_e state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   row_idx_q, row_idx_d;
  logic [9:0]   row_data_q, row_data_d;

  logic start_ok;
  logic settle_last;
  logic handshake;

  assign start_ok    = (state_q == StIdle) && start && !abort;
  assign settle_last = (cnt_q == SettleLast);
  assign handshake   = (state_q == StOut) && row_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over a simultaneous handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StSettle;
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (settle_last) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (abort) begin
          state_d = StIdle;
        end else if (row_ready) begin
          state_d = (idx_q == IDX_LAST) ? StDone : StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    wxyz      = 4'h0;
    row_valid = 1'b0;
    busy      = (state_q != StIdle);
    done      = 1'b0;
    unique case (state_q)
      StIdle:   ;
      StSettle: wxyz = idx_q;
      StOut: begin
        wxyz      = idx_q;
        row_valid = 1'b1;
      end
      StDone:   done = 1'b1;
      default:  ;
    endcase
  end

  // Datapath next state: row index, settle counter and the captured row.
  always_comb begin
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    row_idx_d  = row_idx_q;
    row_data_d = row_data_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          idx_d = 4'd0;
          cnt_d = 4'd0;
        end
      end
      StSettle: begin
        if (!abort) begin
          if (settle_last) begin
            row_idx_d  = idx_q;
            row_data_d = f_in;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StOut: begin
        // The last row leaves idx at 15 so it never wraps.
        if (!abort && row_ready && (idx_q != IDX_LAST)) begin
          idx_d = idx_q + 4'd1;
          cnt_d = 4'd0;
        end
      end
      StDone: ;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= 4'd0;
      cnt_q      <= 4'd0;
      row_idx_q  <= 4'd0;
      row_data_q <= 10'd0;
    end else begin
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      row_idx_q  <= row_idx_d;
      row_data_q <= row_data_d;
    end
  end

  assign row_idx  = row_idx_q;
  assign row_data = row_data_q;

`ifdef SWEEP_SIG_EN
  logic misr_load;
  logic misr_en;

  assign misr_load = start_ok;
  assign misr_en   = handshake && !abort;

  sweep_misr u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (misr_load),
    .en   (misr_en),
    .din  (row_data_q),
    .sig  (sig)
  );
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
  assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_sweep_ctrl.sv
// Randomized self-checking bench for sweep_ctrl: one instance with a direct loopback
// datapath (settle 1) and one with a two-cycle delayed datapath (settle 3).
module tb_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a  [2];
  logic        abort_a  [2];
  logic        ready_a  [2];
  logic [3:0]  wxyz_a   [2];
  logic [9:0]  f_in_a   [2];
  logic        valid_a  [2];
  logic [3:0]  row_idx_a[2];
  logic [9:0]  row_dat_a[2];
  logic        busy_a   [2];
  logic        done_a   [2];
  logic [15:0] sig_a    [2];

  logic [3:0] dly1, dly2;
  int n_checks = 0;
  int n_fail   = 0;

  // Loopback datapath models: direct, and delayed by two clocks.
  assign f_in_a[0] = {6'b0, wxyz_a[0]};
  always @(posedge clk) begin
    dly1 <= wxyz_a[1];
    dly2 <= dly1;
  end
  assign f_in_a[1] = {6'b0, dly2};

  sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a[0]), .abort(abort_a[0]), .wxyz(wxyz_a[0]),
    .f_in(f_in_a[0]), .row_valid(valid_a[0]), .row_ready(ready_a[0]),
    .row_idx(row_idx_a[0]), .row_data(row_dat_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .sig(sig_a[0])
  );

  sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_a[1]), .abort(abort_a[1]), .wxyz(wxyz_a[1]),
    .f_in(f_in_a[1]), .row_valid(valid_a[1]), .row_ready(ready_a[1]),
    .row_idx(row_idx_a[1]), .row_data(row_dat_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .sig(sig_a[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signature as polynomial arithmetic over GF(2): multiply by x, reduce, add the data.
  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [9:0] d);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ {6'b0, d};
  endfunction

  function automatic logic [15:0] sig_expect(input logic [15:0] model);
`ifdef SWEEP_SIG_EN
    return model;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int w, input string tag);
    check({tag, "_busy"}, busy_a[w], 1'b0);
    check({tag, "_done"}, done_a[w], 1'b0);
    check({tag, "_valid"}, valid_a[w], 1'b0);
    check({tag, "_wxyz"}, wxyz_a[w], 4'h0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 5 cycles at row 7.
  task automatic run_sweep(input int w, input int mode);
    int          cyc;
    int          next_row;
    int          stall_left;
    int          settle;
    bit          seen_done;
    logic [15:0] msig;
    settle     = (w == 0) ? 1 : 3;
    start_a[w] = 1'b1;
    ready_a[w] = 1'b1;
    step();
    start_a[w] = 1'b0;
    cyc        = 1;
    next_row   = 0;
    stall_left = 5;
    seen_done  = 1'b0;
    msig       = 16'hFFFF;
    check("busy_after_start", busy_a[w], 1'b1);
    while (cyc < 2000 && !seen_done) begin
      start_a[w] = 1'b0;
      if (mode == 1) begin
        ready_a[w] = 1'($urandom_range(0, 1));
      end else if (mode == 2 && valid_a[w] && row_idx_a[w] == 4'd7 && stall_left > 0) begin
        ready_a[w] = 1'b0;
        stall_left--;
      end else begin
        ready_a[w] = 1'b1;
      end
      if (valid_a[w]) begin
        check("row_idx", row_idx_a[w], next_row);
        check("row_data", row_dat_a[w], next_row);
        check("wxyz_out", wxyz_a[w], next_row);
        if (ready_a[w]) begin
          msig = misr_ref(msig, 10'(next_row));
          next_row++;
        end
      end else if (busy_a[w] && !done_a[w]) begin
        check("wxyz_settle", wxyz_a[w], next_row);
      end
      if (done_a[w]) begin
        seen_done = 1'b1;
        check("rows_before_done", next_row, 16);
        if (mode == 0) check("done_latency", cyc, 1 + 16 * (settle + 1));
        if (mode == 2) check("stall_used", stall_left, 0);
        check("sig_at_done", sig_a[w], sig_expect(msig));
      end else begin
        // Start pulses while busy must be ignored.
        if (busy_a[w] && $urandom_range(0, 3) == 0) start_a[w] = 1'b1;
        step();
        cyc++;
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    start_a[w] = 1'b0;
    ready_a[w] = 1'b0;
    step();
    check_idle(w, "after_done");
    check("sig_hold", sig_a[w], sig_expect(msig));
  endtask

  // Run until row 4 is presented, then abort alongside an asserted ready.
  task automatic abort_test();
    int guard;
    start_a[0] = 1'b1;
    ready_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    guard = 0;
    while (!(valid_a[0] && row_idx_a[0] == 4'd4) && guard < 200) begin
      step();
      guard++;
    end
    check("abort_reach_row4", guard < 200, 1'b1);
    abort_a[0] = 1'b1;
    step();
    abort_a[0] = 1'b0;
    ready_a[0] = 1'b0;
    check_idle(0, "abort");
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done", done_a[0], 1'b0);
    end
  endtask

  // Assert reset between clock edges while a row is settling mid-sweep.
  task automatic reset_test();
    int guard;
    start_a[0] = 1'b1;
    ready_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    guard = 0;
    while (!(valid_a[0] && row_idx_a[0] == 4'd5) && guard < 200) begin
      step();
      guard++;
    end
    step();
    check("rst_pre_settle", busy_a[0] && !valid_a[0], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_idle(0, "async_rst");
    check("async_rst_row_idx", row_idx_a[0], 4'h0);
    check("async_rst_row_data", row_dat_a[0], 10'h0);
    check("async_rst_sig", sig_a[0], 16'h0000);
    ready_a[0] = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin
      start_a[w] = 1'b0;
      abort_a[w] = 1'b0;
      ready_a[w] = 1'b0;
    end
    #12;
    for (int w = 0; w < 2; w++) begin
      check_idle(w, "reset");
      check("reset_row_idx", row_idx_a[w], 4'h0);
      check("reset_row_data", row_dat_a[w], 10'h0);
      check("reset_sig", sig_a[w], 16'h0000);
    end
    step();
    rst = 1'b0;
    step();

    // Start with abort in IDLE stays idle.
    start_a[0] = 1'b1;
    abort_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    abort_a[0] = 1'b0;
    check_idle(0, "start_abort");

    run_sweep(0, 0);
    run_sweep(1, 0);
    run_sweep(0, 2);
    for (int r = 0; r < 3; r++) begin
      run_sweep(0, 1);
      run_sweep(1, 1);
    end
    abort_test();
    run_sweep(0, 0);
    reset_test();
    run_sweep(0, 0);
    run_sweep(1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
